// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit.
// Five-state FSM decoding op/func into datapath enables, mux selects and the
// 4-bit ALU operation code; consumes the ALU zero flag for branch resolution.
// Optional build macro MC_MEM_STALL_EN adds a mem_ready handshake that holds
// the FSM in IF and MEM until memory responds.
//
// state | meaning
// ------+---------------------------------------------------------------
// IF    | fetch: IR <- mem[PC], PC <- PC + 4
// ID    | decode, branch target into ALU result reg, j/jal/jr complete
// EXE   | ALU operation, address calculation or branch resolution
// MEM   | data memory access for lw/sw
// WB    | register file write-back
module mc_control_unit (
  input  logic       clk,
  input  logic       clrn,
`ifdef MC_MEM_STALL_EN
  input  logic       mem_ready,
`endif
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [1:0] pcsource,
  output logic [3:0] aluc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_e state_q, state_d;
  logic   mem_rdy;

`ifdef MC_MEM_STALL_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_j, i_jal, i_beq, i_bne;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw;
  logic is_r_alu, is_shift, is_imm_alu, is_branch, is_jump, is_legal;

  assign r_type = (op == 6'b000000);
  assign i_add  = r_type && (func == 6'b100000);
  assign i_sub  = r_type && (func == 6'b100010);
  assign i_and  = r_type && (func == 6'b100100);
  assign i_or   = r_type && (func == 6'b100101);
  assign i_xor  = r_type && (func == 6'b100110);
  assign i_sll  = r_type && (func == 6'b000000);
  assign i_srl  = r_type && (func == 6'b000010);
  assign i_sra  = r_type && (func == 6'b000011);
  assign i_jr   = r_type && (func == 6'b001000);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lui  = (op == 6'b001111);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);

  assign is_shift   = i_sll | i_srl | i_sra;
  assign is_r_alu   = i_add | i_sub | i_and | i_or | i_xor | is_shift;
  assign is_imm_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign is_branch  = i_beq | i_bne;
  assign is_jump    = i_j | i_jal | i_jr;
  assign is_legal   = is_r_alu | is_imm_alu | is_branch | is_jump | i_lw | i_sw;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!clrn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state logic; unknown opcodes retire after ID as a NOP
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = mem_rdy ? S_ID : S_IF;
      S_ID:  state_d = (is_jump || !is_legal) ? S_IF : S_EXE;
      S_EXE: begin
        if (is_branch)         state_d = S_IF;
        else if (i_lw || i_sw) state_d = S_MEM;
        else                   state_d = S_WB;
      end
      S_MEM: begin
        if (!mem_rdy) state_d = S_MEM;
        else          state_d = i_lw ? S_WB : S_IF;
      end
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // ALU operation used in EXE, selected from the decoded instruction
  logic [3:0] aluc_exe;
  always_comb begin
    aluc_exe = ALU_ADD;
    if (i_sub || is_branch)     aluc_exe = ALU_SUB;
    else if (i_and || i_andi)   aluc_exe = ALU_AND;
    else if (i_or  || i_ori)    aluc_exe = ALU_OR;
    else if (i_xor || i_xori)   aluc_exe = ALU_XOR;
    else if (i_lui)             aluc_exe = ALU_LUI;
    else if (i_sll)             aluc_exe = ALU_SLL;
    else if (i_srl)             aluc_exe = ALU_SRL;
    else if (i_sra)             aluc_exe = ALU_SRA;
  end

  // Output decode; while in reset, present IF values with all writes blocked
  always_comb begin
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    sext     = 1'b0;
    pcsource = 2'b00;
    aluc     = ALU_ADD;
    if (!clrn) begin
      alusrcb = 2'b01;
    end else begin
      case (state_q)
        S_IF: begin
          wpc     = mem_rdy;
          wir     = mem_rdy;
          alusrcb = 2'b01;
        end
        S_ID: begin
          alusrcb = 2'b11;
          sext    = 1'b1;
          if (i_j || i_jal) begin
            wpc      = 1'b1;
            pcsource = 2'b11;
          end
          if (i_jal) begin
            wreg = 1'b1;
            jal  = 1'b1;
          end
          if (i_jr) begin
            wpc      = 1'b1;
            pcsource = 2'b10;
          end
        end
        S_EXE: begin
          alusrca = 1'b1;
          aluc    = aluc_exe;
          if (is_r_alu) begin
            alusrcb = 2'b00;
            shift   = is_shift;
          end else if (is_branch) begin
            alusrcb = 2'b00;
            sext    = 1'b1;
            if ((i_beq && z) || (i_bne && !z)) begin
              wpc      = 1'b1;
              pcsource = 2'b01;
            end
          end else begin
            alusrcb = 2'b10;
            sext    = i_addi | i_lw | i_sw;
          end
        end
        S_MEM: begin
          iord = 1'b1;
          wmem = i_sw && mem_rdy;
        end
        S_WB: begin
          wreg  = 1'b1;
          regrt = is_imm_alu | i_lw;
          m2reg = i_lw;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: randomized instruction stream with
// directed cases up front, expected outputs from a per-instruction phase-list
// model pushed into a scoreboard and compared by a negedge monitor.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       z = 1'b0;
`ifdef MC_MEM_STALL_EN
  logic       mem_ready = 1'b1;
`endif
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca, sext;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .clrn(clrn),
`ifdef MC_MEM_STALL_EN
    .mem_ready(mem_ready),
`endif
    .op(op), .func(func), .z(z),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .alusrca(alusrca), .alusrcb(alusrcb),
    .sext(sext), .pcsource(pcsource), .aluc(aluc), .state(state)
  );

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_JR,
    K_J, K_JAL, K_BEQ, K_BNE, K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI,
    K_LW, K_SW, K_NOP
  } kind_e;

  typedef enum int {P_IF, P_ID, P_EXE, P_MEM, P_WB} phase_e;

  typedef struct packed {
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic [1:0] pcsource;
    logic [3:0] aluc;
  } ctl_t;

  typedef struct {
    ctl_t       ctl;
    logic [2:0] st;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    int         zmode;     // 0: z=0, 1: z=1, 2: random each cycle
    int         rst_exe;   // reset length to apply on reaching EXE
    int         stall_mem; // cycles of mem_ready=0 on reaching MEM
  } instr_t;

  exp_t   sb[$];
  instr_t dq[$];
  phase_e seq[$];
  int     checks = 0;
  int     errors = 0;
  ctl_t   act;

  assign act = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca,
                alusrcb, sext, pcsource, aluc};

  logic [5:0] legal_ops [12] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd12,
                                 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
  logic [5:0] r_funcs [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b000000, 6'b000010, 6'b000011,
                              6'b001000};

  function automatic kind_e classify(logic [5:0] o, logic [5:0] f);
    case (o)
      6'b000000:
        case (f)
          6'b100000: return K_ADD;
          6'b100010: return K_SUB;
          6'b100100: return K_AND;
          6'b100101: return K_OR;
          6'b100110: return K_XOR;
          6'b000000: return K_SLL;
          6'b000010: return K_SRL;
          6'b000011: return K_SRA;
          6'b001000: return K_JR;
          default:   return K_NOP;
        endcase
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b001000: return K_ADDI;
      6'b001100: return K_ANDI;
      6'b001101: return K_ORI;
      6'b001110: return K_XORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(kind_e k);
    case (k)
      K_SUB, K_BEQ, K_BNE: return 4'b0100;
      K_AND, K_ANDI:       return 4'b0001;
      K_OR,  K_ORI:        return 4'b0101;
      K_XOR, K_XORI:       return 4'b0010;
      K_LUI:               return 4'b0110;
      K_SLL:               return 4'b0011;
      K_SRL:               return 4'b0111;
      K_SRA:               return 4'b1111;
      default:             return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] code_of(phase_e p);
    case (p)
      P_IF:    return 3'b000;
      P_ID:    return 3'b001;
      P_EXE:   return 3'b010;
      P_MEM:   return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  // Phase list follows the cycle counts: jumps/NOP 2, branches 3, ALU/sw 4, lw 5
  task automatic build_seq(input kind_e k);
    seq = {P_IF, P_ID};
    if (k inside {K_J, K_JAL, K_JR, K_NOP}) return;
    seq.push_back(P_EXE);
    if (k inside {K_BEQ, K_BNE}) return;
    if (k inside {K_LW, K_SW}) seq.push_back(P_MEM);
    if (k != K_SW) seq.push_back(P_WB);
  endtask

  function automatic ctl_t exp_ctl(phase_e p, kind_e k, logic zz, logic in_rst, logic rdy);
    ctl_t c = '0;
    bit rk = k inside {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA};
    bit ik = k inside {K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI};
    if (in_rst) begin
      c.alusrcb = 2'b01;
      return c;
    end
    case (p)
      P_IF: begin
        c.wpc = rdy; c.wir = rdy; c.alusrcb = 2'b01;
      end
      P_ID: begin
        c.alusrcb = 2'b11; c.sext = 1'b1;
        if (k == K_J || k == K_JAL) begin c.wpc = 1'b1; c.pcsource = 2'b11; end
        if (k == K_JAL) begin c.wreg = 1'b1; c.jal = 1'b1; end
        if (k == K_JR) begin c.wpc = 1'b1; c.pcsource = 2'b10; end
      end
      P_EXE: begin
        c.alusrca = 1'b1;
        c.aluc = alu_of(k);
        if (rk) begin
          c.alusrcb = 2'b00;
          c.shift = k inside {K_SLL, K_SRL, K_SRA};
        end else if (k == K_BEQ || k == K_BNE) begin
          c.alusrcb = 2'b00;
          c.sext = 1'b1;
          if ((k == K_BEQ) ? zz : !zz) begin c.wpc = 1'b1; c.pcsource = 2'b01; end
        end else begin
          c.alusrcb = 2'b10;
          c.sext = (k == K_ADDI || k == K_LW || k == K_SW);
        end
      end
      P_MEM: begin
        c.iord = 1'b1;
        c.wmem = (k == K_SW) && rdy;
      end
      default: begin
        c.wreg = 1'b1;
        c.regrt = ik || k == K_LW;
        c.m2reg = (k == K_LW);
      end
    endcase
    return c;
  endfunction

  task automatic add_dir(input logic [5:0] o, input logic [5:0] f, input int zm,
                         input int re, input int sm);
    instr_t t;
    t.op = o; t.func = f; t.zmode = zm; t.rst_exe = re; t.stall_mem = sm;
    dq.push_back(t);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, act, e.ctl);
      end
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state cyc=%0d got=%b exp=%b", e.cyc, state, e.st);
      end
    end
  end

  initial begin
    instr_t cur;
    kind_e  kind;
    int     idx = 0;
    int     rst_left = 0;
    int     rst_armed = 0;
    int     stall_left = 0;
    bit     need_pick = 1;
    logic   rdy;
    logic   in_rst;
    phase_e ph;
    exp_t   e;

    add_dir(6'b000000, 6'b100000, 2, 2, 0);  // add, reset for 2 cycles at EXE
    add_dir(6'b000000, 6'b100000, 2, 0, 0);  // add
    add_dir(6'b100011, 6'b000000, 2, 0, 0);  // lw
    add_dir(6'b000000, 6'b000011, 2, 0, 0);  // sra
    add_dir(6'b000100, 6'b000000, 1, 0, 0);  // beq z=1
    add_dir(6'b000100, 6'b000000, 0, 0, 0);  // beq z=0
    add_dir(6'b000101, 6'b000000, 0, 0, 0);  // bne z=0
    add_dir(6'b000101, 6'b000000, 1, 0, 0);  // bne z=1
    add_dir(6'b000011, 6'b000000, 2, 0, 0);  // jal
    add_dir(6'b000010, 6'b000000, 2, 0, 0);  // j
    add_dir(6'b000000, 6'b001000, 2, 0, 0);  // jr
    add_dir(6'b111111, 6'b000000, 2, 0, 0);  // illegal op
    add_dir(6'b000000, 6'b111111, 2, 0, 0);  // R-type, unknown func
    add_dir(6'b101011, 6'b000000, 2, 0, 3);  // sw, memory stalls 3 cycles
    add_dir(6'b001111, 6'b000000, 2, 0, 0);  // lui
    add_dir(6'b001100, 6'b000000, 2, 0, 0);  // andi

    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_left = 1;  // one more reset cycle with state now known to be IF

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (need_pick) begin
        if (dq.size() > 0) begin
          cur = dq.pop_front();
        end else begin
          cur.op = ($urandom_range(9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(11)];
          cur.func = ($urandom_range(9) == 0) ? 6'($urandom) : r_funcs[$urandom_range(8)];
          cur.zmode = 2; cur.rst_exe = 0; cur.stall_mem = 0;
        end
        op = cur.op; func = cur.func;
        kind = classify(cur.op, cur.func);
        build_seq(kind);
        rst_armed = cur.rst_exe;
        stall_left = cur.stall_mem;
        need_pick = 0;
      end
      ph = seq[idx];

      rdy = 1'b1;
`ifdef MC_MEM_STALL_EN
      if (ph == P_MEM && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(3) != 0);
      end
      mem_ready = rdy;
`else
      if (stall_left > 0) stall_left = 0;
`endif

      if (rst_left == 0 && rst_armed > 0 && ph == P_EXE) begin
        rst_left = rst_armed;
        rst_armed = 0;
      end else if (rst_left == 0 && cyc > 60 && $urandom_range(63) == 0) begin
        rst_left = 1 + $urandom_range(1);
      end
      in_rst = (rst_left > 0);
      clrn = !in_rst;
      z = (cur.zmode == 2) ? 1'($urandom_range(1)) : (cur.zmode == 1);

      e.ctl = exp_ctl(ph, kind, z, in_rst, rdy);
      e.st  = code_of(ph);
      e.cyc = cyc;
      sb.push_back(e);

      if (in_rst) begin
        rst_left--;
        idx = 0;
      end else if ((ph == P_IF || ph == P_MEM) && !rdy) begin
        idx = idx;
      end else begin
        idx++;
        if (idx == seq.size()) begin
          idx = 0;
          need_pick = 1;
        end
      end

      @(posedge clk);
      #1;
    end

    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle MIPS control unit: five-state FSM that decodes op/func and drives datapath enables, mux selects and the 4-bit aluc code consumed by the ALU.
- Producer side of the aluc/z interface: emits aluc, receives the ALU zero flag z back for branch resolution.
- Sits between instruction register and datapath in the multi-cycle CPU top.

Parameters:
- None. Encodings are fixed; see Behaviour.

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  synchronous active-low reset
- op  in  6  instruction[31:26] from IR
- func  in  6  instruction[5:0] from IR
- z  in  1  ALU zero flag
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  data memory write enable
- wreg  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- regrt  out  1  destination register: 0 = rd, 1 = rt
- m2reg  out  1  write-back data: 0 = ALU result, 1 = memory data register
- jal  out  1  write-back to $31 with PC
- shift  out  1  ALU A = sa (instruction[10:6])
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B: 00 = reg B, 01 = 4, 10 = imm, 11 = imm<<2
- sext  out  1  immediate sign-extend (1) or zero-extend (0)
- pcsource  out  2  next PC: 00 = ALU, 01 = ALU result register, 10 = reg A, 11 = jump address
- aluc  out  4  ALU operation code
- state  out  3  current FSM state, for debug

Behaviour:
- Single clock. Reset is synchronous and active-low: clrn=0 at a rising edge forces state=IF.
- While clrn=0, wpc, wir, wmem and wreg are forced to 0. All other outputs follow their IF values.
- All outputs are combinational from state, op, func and z.
- Default for any output not listed in a state: 0.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100.
- aluc codes: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- Opcodes:
  - R=000000, j=000010, jal=000011, beq=000100, bne=000101
  - addi=001000, andi=001100, ori=001101, xori=001110, lui=001111
  - lw=100011, sw=101011
- R-type func codes: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
- IF state: iord=0, wir=1, wpc=1, alusrca=0, alusrcb=01, aluc=add, pcsource=00 (PC <- PC+4). Next: ID.
- ID state: alusrca=0, alusrcb=11, sext=1, aluc=add (branch target computed into the ALU result register).
  - j: wpc=1, pcsource=11.
  - jal: same as j, plus wreg=1, jal=1.
  - jr: wpc=1, pcsource=10.
  - j/jal/jr next state: IF.
  - Illegal op, or R-type with an unlisted func: no writes, next state IF (executes as NOP).
  - All other instructions: next state EXE.
- EXE state:
  - R-type ALU ops: alusrca=1, alusrcb=00. Shifts also set shift=1.
  - I-type ops and lw/sw: alusrca=1, alusrcb=10.
  - sext=1 for addi/lw/sw/beq/bne; sext=0 for andi/ori/xori/lui.
  - lw/sw use aluc=add; beq/bne use aluc=sub with alusrcb=00.
  - Branch taken when beq with z=1, or bne with z=0: wpc=1, pcsource=01.
  - Next state: beq/bne -> IF; lw/sw -> MEM; all others -> WB.
- MEM state: iord=1.
  - sw: wmem=1, next state IF.
  - lw: next state WB.
- WB state: wreg=1; regrt=1 for I-type and lw; m2reg=1 for lw only. Next state IF.
- Cycle counts: j/jal/jr 2; beq/bne 3; R-type/I-type ALU 4; sw 4; lw 5.
- Reset mid-instruction aborts it: no write enable asserts in that cycle, and the FSM restarts at IF.
- op/func must be stable from ID onward (the IR is only written in IF).

Optional Feature:
- Macro: MC_MEM_STALL_EN.
- When defined: adds input mem_ready (1 bit).
  - In IF, wpc and wir assert only when mem_ready=1. The FSM holds in IF otherwise.
  - In MEM, wmem asserts and the state advances only when mem_ready=1. The FSM holds in MEM otherwise.
- When undefined: no mem_ready port; memory is assumed single-cycle, behaviour as above.

Test Plan:
- clrn=0 for 2 cycles mid-EXE of an add -> state=000, wpc=wir=wmem=wreg=0 during reset; after release, IF outputs with alusrcb=01, aluc=0000.
- R add (op=0, func=100000) -> states 000,001,010,100,000; EXE aluc=0000, alusrcb=00; WB wreg=1, regrt=0.
- lw (op=100011) -> 5 cycles; MEM iord=1; WB m2reg=1, regrt=1; sra (func=000011) EXE aluc=1111, shift=1.
- beq with z=1 -> EXE wpc=1, pcsource=01, next IF. beq with z=0 -> wpc=0. bne with z=0 -> taken; aluc=0100 in each case.
- jal (op=000011) -> ID wpc=1, pcsource=11, wreg=1, jal=1, next IF. Illegal op 111111 -> ID no writes, next IF.
- With MC_MEM_STALL_EN, sw and mem_ready=0 for 3 cycles -> FSM holds in MEM with wmem=0; wmem=1 on the first cycle with mem_ready=1, then IF.
